chain_walker: RTL and testbench

Rainbow-chain iteration engine. It sits around the reduction stage: it issues a 56-bit DES key to an external DES core and takes back the 64-bit ciphertext. That ciphertext is XORed with the step index and passed through `redux_lfsr`, which is instantiated internally and is purely combinational. The result becomes the next chain state. After `CHAIN_LEN` steps, the block presents the start point and end point of the chain to the table writer.

---
 rtl/chain_walker.sv | 80 ++++++++
 tb/tb_chain_walker.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/chain_walker.sv
// chain_walker: rainbow-chain engine alternating external DES steps with an internal LFSR reduction.
module redux_lfsr (
  input  logic [63:0] din,
  output logic [63:0] dout
);
  always_comb begin
    dout = din;
    for (int i = 0; i < 64; i++) dout = {dout[62:0], dout[63] ^ dout[62] ^ dout[60] ^ dout[59]};
  end
endmodule

module chain_walker #(
  parameter int CHAIN_LEN = 4096,
  parameter int STEP_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [63:0] start_point,
  output logic        des_key_valid,
  input  logic        des_key_ready,
  output logic [55:0] des_key,
  input  logic        des_ct_valid,
  input  logic [63:0] des_ct,
  output logic        end_valid,
  input  logic        end_ready,
  output logic [63:0] end_start,
  output logic [63:0] end_point,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0] fsm_q, fsm_d;
  logic [63:0] state_q, state_d, seed_q, seed_d, redux_out, step_x;
  logic [STEP_W-1:0] step_q, step_d;
  logic last;
  assign step_x = 64'(step_q);
  assign last = step_q == STEP_W'(CHAIN_LEN - 1);
  redux_lfsr u_redux (.din(des_ct ^ step_x), .dout(redux_out));
  always_comb begin
    fsm_d = fsm_q;
    state_d = state_q;
    seed_d = seed_q;
    step_d = step_q;
    if (fsm_q == IDLE && start_valid) begin
      fsm_d = ISSUE;
      state_d = start_point;
      seed_d = start_point;
      step_d = '0;
    end
    if (fsm_q == ISSUE && des_key_ready) fsm_d = WAIT;
    // ciphertext outside WAIT is stray and must not touch the chain
    if (fsm_q == WAIT && des_ct_valid) begin
      state_d = redux_out;
      step_d = step_q + 1'b1;
      fsm_d = last ? DONE : ISSUE;
    end
    if (fsm_q == DONE && end_ready) fsm_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      state_q <= '0;
      seed_q <= '0;
      step_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      state_q <= state_d;
      seed_q <= seed_d;
      step_q <= step_d;
    end
  end
  assign start_ready = fsm_q == IDLE;
  assign des_key_valid = fsm_q == ISSUE;
  assign des_key = state_q[55:0];
  assign end_valid = fsm_q == DONE;
  assign end_start = seed_q;
  assign end_point = state_q;
  assign busy = fsm_q != IDLE;
endmodule

// File: tb/tb_chain_walker.sv
// tb_chain_walker: three chain lengths driven from a vector table against a software chain model.
module tb_chain_walker;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst;
  logic sv[3], kr[3], cv[3], er[3];
  logic [63:0] sp[3], ct[3];
  logic sr[3], kv[3], ev[3], by[3];
  logic [55:0] key[3];
  logic [63:0] es[3], ep[3];
  int cl[3] = '{1, 2, 64};
  int vecs = 0, errs = 0;

  typedef struct {
    int d;
    logic [63:0] sp;
    bit zero;
    int lat;
    int kr;
    int er;
    bit stray;
    logic [63:0] exp_ep;
  } vec_t;
  vec_t tbl[15];

  chain_walker #(.CHAIN_LEN(1)) u0 (.clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(sr[0]),
    .start_point(sp[0]), .des_key_valid(kv[0]), .des_key_ready(kr[0]), .des_key(key[0]),
    .des_ct_valid(cv[0]), .des_ct(ct[0]), .end_valid(ev[0]), .end_ready(er[0]),
    .end_start(es[0]), .end_point(ep[0]), .busy(by[0]));
  chain_walker #(.CHAIN_LEN(2)) u1 (.clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(sr[1]),
    .start_point(sp[1]), .des_key_valid(kv[1]), .des_key_ready(kr[1]), .des_key(key[1]),
    .des_ct_valid(cv[1]), .des_ct(ct[1]), .end_valid(ev[1]), .end_ready(er[1]),
    .end_start(es[1]), .end_point(ep[1]), .busy(by[1]));
  chain_walker #(.CHAIN_LEN(64), .STEP_W(8)) u2 (.clk(clk), .rst(rst), .start_valid(sv[2]), .start_ready(sr[2]),
    .start_point(sp[2]), .des_key_valid(kv[2]), .des_key_ready(kr[2]), .des_key(key[2]),
    .des_ct_valid(cv[2]), .des_ct(ct[2]), .end_valid(ev[2]), .end_ready(er[2]),
    .end_start(es[2]), .end_point(ep[2]), .busy(by[2]));

  function automatic logic [63:0] lfsr_ref(input logic [63:0] x);
    for (int i = 0; i < 64; i++) x = (x << 1) | 64'(^(x & 64'hD800_0000_0000_0000));
    return x;
  endfunction

  // stand-in cipher: any fixed keyed mixing exercises the walker identically
  function automatic logic [63:0] des_fn(input logic [55:0] k);
    logic [63:0] x;
    x = {8'h5A, k} * 64'h9E37_79B9_7F4A_7C15;
    return x ^ (x >> 29) ^ 64'h0F1E_2D3C_4B5A_6978;
  endfunction

  function automatic logic [63:0] chain_model(input logic [63:0] s0, input int n, input bit zero);
    logic [63:0] s = s0;
    for (int i = 0; i < n; i++) s = lfsr_ref((zero ? 64'h0 : des_fn(s[55:0])) ^ 64'(i));
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int d = v.d, n = 0, lat, w;
    logic [63:0] s = v.sp, c, p0;
    logic [55:0] k0;
    bit ok = 1, hold_ok = 1;
    if (v.stray) begin
      cv[d] = 1; ct[d] = '1; tick(); cv[d] = 0;
    end
    sv[d] = 1; sp[d] = v.sp;
    w = 0;
    while (!sr[d] && w < 100) begin tick(); w++; end
    tick(); sv[d] = 0;
    chk("busy_after_start", 64'(by[d]), 64'd1);
    for (int i = 0; i < 200; i++) begin
      w = 0;
      while (!kv[d] && w < 50) begin tick(); w++; end
      if (!kv[d] || key[d] !== s[55:0]) ok = 0;
      k0 = key[d];
      for (int j = 0; j < v.kr; j++) begin
        if (v.stray && j == 1) begin cv[d] = 1; ct[d] = '1; end
        tick(); cv[d] = 0;
        if (key[d] !== k0 || !kv[d]) ok = 0;
      end
      kr[d] = 1; tick(); kr[d] = 0; n++;
      if (kv[d]) ok = 0;
      c = v.zero ? 64'h0 : des_fn(k0);
      lat = v.lat != 0 ? v.lat : int'($urandom_range(1, 20));
      repeat (lat - 1) tick();
      cv[d] = 1; ct[d] = c; tick(); cv[d] = 0; ct[d] = '0;
      s = lfsr_ref(c ^ 64'(n - 1));
      if (ev[d]) break;
    end
    chk("end_valid_next", 64'(ev[d]), 64'd1);
    chk("steps", 64'(n), 64'(cl[d]));
    chk("keys", 64'(ok), 64'd1);
    p0 = ep[d];
    for (int j = 0; j < v.er; j++) begin
      if (v.stray && j == 2) begin cv[d] = 1; ct[d] = '1; end
      tick(); cv[d] = 0;
      if (ep[d] !== p0 || !ev[d] || es[d] !== v.sp || kv[d]) hold_ok = 0;
    end
    chk("end_point", ep[d], v.exp_ep);
    chk("end_start", es[d], v.sp);
    chk("end_hold", 64'(hold_ok), 64'd1);
    er[d] = 1; tick(); er[d] = 0;
    chk("start_ready_after_end", 64'(sr[d]), 64'd1);
    chk("end_valid_drop", 64'(ev[d]), 64'd0);
  endtask

  initial begin
    bit quiet;
    for (int d = 0; d < 3; d++) begin
      sv[d] = 0; kr[d] = 0; cv[d] = 0; er[d] = 0; sp[d] = '0; ct[d] = '0;
    end
    rst = 1;
    repeat (3) tick();
    rst = 0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_start_ready", 64'(sr[d]), 64'd1);
      chk("rst_key_valid", 64'(kv[d]), 64'd0);
      chk("rst_end_valid", 64'(ev[d]), 64'd0);
      chk("rst_busy", 64'(by[d]), 64'd0);
      chk("rst_key", 64'(key[d]), 64'd0);
      chk("rst_end_point", ep[d], 64'd0);
      chk("rst_end_start", es[d], 64'd0);
    end
    sv[2] = 1; sp[2] = {$urandom, $urandom}; tick(); sv[2] = 0;
    chk("mid_key_valid", 64'(kv[2]), 64'd1);
    kr[2] = 1; tick(); kr[2] = 0;
    chk("mid_busy_wait", 64'(by[2]), 64'd1);
    rst = 1; tick(); rst = 0;
    chk("mid_rst_busy", 64'(by[2]), 64'd0);
    chk("mid_rst_start_ready", 64'(sr[2]), 64'd1);
    chk("mid_rst_end_point", ep[2], 64'd0);
    cv[2] = 1; ct[2] = {$urandom, $urandom}; tick(); cv[2] = 0;
    quiet = 1;
    repeat (5) begin
      if (ev[2] || by[2] || kv[2] || ep[2] !== 64'd0) quiet = 0;
      tick();
    end
    chk("mid_rst_stray_ct", 64'(quiet), 64'd1);
    tbl[0] = '{0, 64'h0, 1, 1, 0, 0, 0, 64'h0};
    tbl[1] = '{1, 64'h0123_4567_89AB_CDEF, 1, 1, 0, 0, 0, 64'h0};
    tbl[2] = '{1, 64'h0123_4567_89AB_CDEF, 1, 3, 5, 7, 1, 64'h0};
    tbl[3] = '{0, {$urandom, $urandom}, 0, 2, 1, 1, 0, 64'h0};
    tbl[4] = '{2, {$urandom, $urandom}, 0, 0, 5, 7, 1, 64'h0};
    for (int i = 5; i < 15; i++) tbl[i] = '{2, {$urandom, $urandom}, 0, 0, 0, 0, 0, 64'h0};
    for (int i = 0; i < 15; i++) tbl[i].exp_ep = chain_model(tbl[i].sp, cl[tbl[i].d], tbl[i].zero);
    for (int i = 0; i < 15; i++) run(tbl[i]);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
